uart_tx_mmio: RTL

- Memory-mapped UART transmitter on the CPU data bus, directly downstream of the cpu block.
- Consumes the CPU's address, read_write and data_write outputs.
- Buffers written bytes in a small FIFO and serialises them as 8N1 frames on a tx pin.
- Returns a status byte on data_read; the output is zero when not addressed so it can be ORed into the system read bus.

---
 rtl/uart_tx_mmio.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO behind a DATA/STATUS register pair, 8N1 serialiser.
// Optional: define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_tx_mmio #(
   parameter logic [15:0] BASE_ADDR = 16'hD000,
   parameter int unsigned CLK_DIV   = 434,
   parameter int unsigned FIFO_AW   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   input  logic        read_write,
   input  logic [7:0]  data_write,
   output logic [7:0]  data_read,
   output logic        sel,
   output logic        tx,
   output logic        irq
);
   localparam int unsigned DEPTH     = 1 << FIFO_AW;
   localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

   typedef logic [FIFO_AW:0] ptr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        irq_q, irq_d;
   logic        ovf_q, ovf_d;
   ptr_t        wptr_q, wptr_d, rptr_q, rptr_d;
`ifdef UART_TX_PARITY_EN
   logic        par_q, par_d;
`endif

   logic [7:0]  mem [DEPTH];
   logic [7:0]  head;
   logic [7:0]  status;
   ptr_t        count;
   logic        full, empty, wr_data, wr_stat, push, pop;

   assign sel     = (address == BASE_ADDR) || (address == STAT_ADDR);
   assign wr_data = !read_write && (address == BASE_ADDR);
   assign wr_stat = !read_write && (address == STAT_ADDR);

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
   assign count = wptr_q - rptr_q;
   assign push  = wr_data && !full;
   assign head  = mem[rptr_q[FIFO_AW-1:0]];

   assign status    = {4'(count), ovf_q, (state_q != S_IDLE), empty, full};
   assign data_read = (read_write && (address == STAT_ADDR)) ? status : 8'h00;

   assign tx  = tx_q;
   assign irq = irq_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
`ifdef UART_TX_PARITY_EN
               par_d   = ^head;
`endif
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               // Chain straight into the next start bit so queued bytes leave with no idle gap.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
`ifdef UART_TX_PARITY_EN
                  par_d   = ^head;
`endif
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      wptr_d = wptr_q + ptr_t'(push);
      rptr_d = rptr_q + ptr_t'(pop);

      ovf_d = ovf_q;
      if (wr_stat)
         ovf_d = 1'b0;
      else if (wr_data && full)
         ovf_d = 1'b1;

      // Output registers are loaded from next-state so tx/irq change on the same edge as the FSM.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
      irq_d = (wptr_d == rptr_d) && (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         irq_q   <= 1'b1;
         ovf_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         irq_q   <= irq_d;
         ovf_q   <= ovf_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr_q[FIFO_AW-1:0]] <= data_write;
   end

endmodule
